twiddle_cmult: RTL and testbench

Complex twiddle multiplier stage that sits directly downstream of the twiddle ROM pair (real and imaginary, 5-bit address, registered output, Q8 coefficients where 0x0100 = 1.0). It accepts a stream of complex samples and generates the per-sample ROM address from a frame counter. It aligns each sample with the one-cycle ROM read latency and emits the product sample × W, rounded and saturated back to the data width. Its output feeds the next butterfly/accumulate stage.

---
 rtl/twiddle_cmult.sv | 138 +++++++++++++
 tb/tb_twiddle_cmult.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/twiddle_cmult.sv
`default_nettype none
// ============================================================================
//  Module   : twiddle_cmult
//  Purpose  : Complex sample x twiddle multiplier. Generates the twiddle ROM
//             address from a frame counter, aligns samples with the one-cycle
//             ROM read latency, and emits a rounded, saturated Q8 product.
//  Revision : 1.0  initial release
// ============================================================================
module twiddle_cmult #(
   parameter int DW        = 16,
   parameter int TW        = 16,
   parameter int AW        = 5,
   parameter int FRAME_LEN = 28
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic          in_sop,
   input  logic [DW-1:0] in_re,
   input  logic [DW-1:0] in_im,
   output logic [AW-1:0] rom_addr,
   input  logic [TW-1:0] rom_re,
   input  logic [TW-1:0] rom_im,
   output logic          out_valid,
   output logic          out_sop,
   output logic          out_eop,
   output logic [DW-1:0] out_re,
   output logic [DW-1:0] out_im
);

   localparam int                    c_PW   = DW + TW;       // product width
   localparam int                    c_SW   = DW + TW + 1;   // sum width
   localparam logic [AW-1:0]         c_LAST = AW'(FRAME_LEN - 1);
   localparam logic signed [c_SW-1:0] c_HALF = c_SW'(128);
   localparam logic signed [c_SW-1:0] c_MAX  = c_SW'((2 ** (DW - 1)) - 1);
   localparam logic signed [c_SW-1:0] c_MIN  = c_SW'(-(2 ** (DW - 1)));

   logic [AW-1:0]           r_cnt;
   logic [AW-1:0]           w_cnt_nxt;
   logic                    w_sop_tag;
   logic                    w_eop_tag;

   logic                    r_s1_valid, r_s1_sop, r_s1_eop;
   logic signed [DW-1:0]    r_s1_re, r_s1_im;

   logic                    r_s2_valid, r_s2_sop, r_s2_eop;
   logic signed [c_PW-1:0]  r_ac, r_bd, r_ad, r_bc;

   logic signed [c_SW-1:0]  w_sum_re, w_sum_im;

   // Round half up at the Q8 binary point, then clamp to the output range
   function automatic logic [DW-1:0] f_round_sat(input logic signed [c_SW-1:0] v);
      logic signed [c_SW-1:0] r;
      r = (v + c_HALF) >>> 8;
      if (r > c_MAX)
         r = c_MAX;
      else if (r < c_MIN)
         r = c_MIN;
      return r[DW-1:0];
   endfunction

   // in_sop forces address 0 so the ROM sees the restart on the same edge
   assign rom_addr  = in_sop ? '0 : r_cnt;
   assign w_cnt_nxt = (rom_addr == c_LAST) ? '0 : rom_addr + 1'b1;
   assign w_sop_tag = in_valid & (rom_addr == '0);
   assign w_eop_tag = in_valid & (rom_addr == c_LAST);

   // Address counter advances only on accepted samples
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_cnt <= '0;
      else if (in_valid)
         r_cnt <= w_cnt_nxt;
   end

   // S1: capture the sample and its frame tags; ROM data lands alongside
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s1_sop   <= 1'b0;
         r_s1_eop   <= 1'b0;
         r_s1_re    <= '0;
         r_s1_im    <= '0;
      end else begin
         r_s1_valid <= in_valid;
         r_s1_sop   <= w_sop_tag;
         r_s1_eop   <= w_eop_tag;
         r_s1_re    <= $signed(in_re);
         r_s1_im    <= $signed(in_im);
      end
   end

   // S2: the four partial products of (a + jb)(c + jd)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s2_valid <= 1'b0;
         r_s2_sop   <= 1'b0;
         r_s2_eop   <= 1'b0;
         r_ac       <= '0;
         r_bd       <= '0;
         r_ad       <= '0;
         r_bc       <= '0;
      end else begin
         r_s2_valid <= r_s1_valid;
         r_s2_sop   <= r_s1_sop;
         r_s2_eop   <= r_s1_eop;
         r_ac       <= r_s1_re * $signed(rom_re);
         r_bd       <= r_s1_im * $signed(rom_im);
         r_ad       <= r_s1_re * $signed(rom_im);
         r_bc       <= r_s1_im * $signed(rom_re);
      end
   end

   // One extra bit so the sum/difference of two full products cannot wrap
   assign w_sum_re = c_SW'(r_ac) - c_SW'(r_bd);
   assign w_sum_im = c_SW'(r_ad) + c_SW'(r_bc);

   // S3: round/saturate into the outputs; data holds when nothing is valid
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_sop   <= 1'b0;
         out_eop   <= 1'b0;
         out_re    <= '0;
         out_im    <= '0;
      end else begin
         out_valid <= r_s2_valid;
         out_sop   <= r_s2_valid & r_s2_sop;
         out_eop   <= r_s2_valid & r_s2_eop;
         if (r_s2_valid) begin
            out_re <= f_round_sat(w_sum_re);
            out_im <= f_round_sat(w_sum_im);
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_twiddle_cmult.sv
`default_nettype none
// ============================================================================
//  Module   : tb_twiddle_cmult
//  Purpose  : Self-checking bench for twiddle_cmult with a registered ROM
//             model and an expected-result queue.
//  Revision : 1.0  initial release
// ============================================================================
module tb_twiddle_cmult;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_sop;
   logic [15:0] in_re, in_im;
   logic [4:0]  rom_addr;
   logic [15:0] rom_re, rom_im;
   logic        out_valid, out_sop, out_eop;
   logic [15:0] out_re, out_im;

   typedef struct {
      logic [15:0] re;
      logic [15:0] im;
      logic        sop;
      logic        eop;
      int          cyc;
   } exp_t;

   exp_t        q[$];
   logic [15:0] tbl_re[32];
   logic [15:0] tbl_im[32];
   logic [4:0]  mcnt = 5'd0;
   int          cyc = 0;
   int          n_checks = 0;
   int          n_fail = 0;

   twiddle_cmult #(.DW(16), .TW(16), .AW(5), .FRAME_LEN(28)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_sop(in_sop), .in_re(in_re), .in_im(in_im),
      .rom_addr(rom_addr), .rom_re(rom_re), .rom_im(rom_im),
      .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
      .out_re(out_re), .out_im(out_im)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Registered twiddle ROM pair
   always @(posedge clk) begin
      rom_re <= tbl_re[rom_addr];
      rom_im <= tbl_im[rom_addr];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] f_rs(input longint v);
      longint r;
      r = (v + 128) >>> 8;
      if (r > 32767) r = 32767;
      if (r < -32768) r = -32768;
      return r[15:0];
   endfunction

   // Output side of the scoreboard
   always @(negedge clk) begin
      if (!rst && out_valid) begin
         if (q.size() == 0) begin
            check("out_valid_unexpected", {31'd0, out_valid}, 32'd0);
         end else begin
            exp_t e;
            e = q.pop_front();
            check("latency", cyc, e.cyc + 3);
            check("out_re", {16'd0, out_re}, {16'd0, e.re});
            check("out_im", {16'd0, out_im}, {16'd0, e.im});
            check("out_sop", {31'd0, out_sop}, {31'd0, e.sop});
            check("out_eop", {31'd0, out_eop}, {31'd0, e.eop});
         end
      end
   end

   task automatic drive(input logic v, input logic s, input logic [15:0] a, input logic [15:0] b);
      exp_t        e;
      logic [4:0]  ea;
      longint      sa, sb, sc, sd;
      @(negedge clk);
      in_valid = v;
      in_sop   = s;
      in_re    = a;
      in_im    = b;
      #1;
      ea = s ? 5'd0 : mcnt;
      check("rom_addr", {27'd0, rom_addr}, {27'd0, ea});
      if (v) begin
         sa = $signed(a);
         sb = $signed(b);
         sc = $signed(tbl_re[ea]);
         sd = $signed(tbl_im[ea]);
         e.re  = f_rs(sa * sc - sb * sd);
         e.im  = f_rs(sa * sd + sb * sc);
         e.sop = (ea == 5'd0);
         e.eop = (ea == 5'd27);
         e.cyc = cyc;
         q.push_back(e);
         mcnt = (ea == 5'd27) ? 5'd0 : ea + 5'd1;
      end
   endtask

   // Change ROM contents only after the last driven sample has been read
   task automatic set_rom(input logic [15:0] c, input logic [15:0] d);
      @(posedge clk);
      #1;
      for (int i = 0; i < 32; i++) begin
         tbl_re[i] = c;
         tbl_im[i] = d;
      end
   endtask

   task automatic pulse_rst();
      @(negedge clk);
      in_valid = 1'b0;
      in_sop   = 1'b0;
      #2;
      rst = 1'b1;
      q.delete();
      mcnt = 5'd0;
      #1;
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_re", {16'd0, out_re}, 32'd0);
      check("rst_rom_addr", {27'd0, rom_addr}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_sop = 1'b0; in_re = '0; in_im = '0;
      for (int i = 0; i < 32; i++) begin
         tbl_re[i] = 16'($urandom_range(0, 512)) - 16'd256;
         tbl_im[i] = 16'($urandom_range(0, 512)) - 16'd256;
      end
      repeat (2) @(negedge clk);
      #1;
      check("reset_out_valid", {31'd0, out_valid}, 32'd0);
      check("reset_out_sop", {31'd0, out_sop}, 32'd0);
      check("reset_out_eop", {31'd0, out_eop}, 32'd0);
      check("reset_out_re", {16'd0, out_re}, 32'd0);
      check("reset_out_im", {16'd0, out_im}, 32'd0);
      check("reset_rom_addr", {27'd0, rom_addr}, 32'd0);
      rst = 1'b0;

      // Full frame plus wrap sample, random data and ROM
      for (int i = 0; i < 29; i++)
         drive(1'b1, i == 0, 16'($urandom), 16'($urandom));

      // Identity twiddle
      set_rom(16'h0100, 16'h0000);
      drive(1'b1, 1'b0, 16'h1234, 16'hF00F);

      // Specific entry at address 9
      set_rom(16'h0100, 16'h0000);
      tbl_re[9] = 16'h00B5;
      tbl_im[9] = 16'hFF4B;
      drive(1'b1, 1'b1, 16'h0007, 16'h0003);
      for (int i = 1; i < 9; i++)
         drive(1'b1, 1'b0, 16'(i * 100), 16'(i));
      drive(1'b1, 1'b0, 16'h0100, 16'h0000);

      // Rounding at exactly one half
      set_rom(16'h0080, 16'h0000);
      drive(1'b1, 1'b0, 16'h0001, 16'h0000);
      drive(1'b1, 1'b0, 16'hFFFF, 16'h0000);

      // Saturation both directions
      set_rom(16'h00B5, 16'hFF4B);
      drive(1'b1, 1'b0, 16'h7FFF, 16'h7FFF);
      set_rom(16'h0100, 16'h0100);
      drive(1'b1, 1'b0, 16'h8000, 16'h8000);

      // Gaps, in_sop mid-frame at address 5, reset with samples in flight
      set_rom(16'h0040, 16'hFFC0);
      drive(1'b1, 1'b1, 16'h1111, 16'h2222);
      drive(1'b0, 1'b0, 16'h0000, 16'h0000);
      drive(1'b0, 1'b0, 16'h0000, 16'h0000);
      drive(1'b1, 1'b0, 16'h3333, 16'h4444);
      for (int i = 0; i < 3; i++)
         drive(1'b1, 1'b0, 16'(i + 5), 16'(i + 9));
      drive(1'b1, 1'b1, 16'h5555, 16'h6666);
      drive(1'b1, 1'b0, 16'h0101, 16'h0202);
      drive(1'b1, 1'b0, 16'h0303, 16'h0404);
      pulse_rst();
      drive(1'b1, 1'b0, 16'h0ABC, 16'hF123);

      // in_sop on the last-address slot wins; no eop tag
      for (int i = 1; i < 27; i++)
         drive(1'b1, 1'b0, 16'($urandom), 16'($urandom));
      drive(1'b1, 1'b1, 16'h0777, 16'h0888);
      drive(1'b1, 1'b0, 16'h0999, 16'h0AAA);

      // Drain with a bounded number of idle cycles
      for (int i = 0; i < 8 && q.size() != 0; i++)
         drive(1'b0, 1'b0, 16'h0000, 16'h0000);
      check("drain", q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
